pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PRESCALE, default 1: clk cycles per measurement tick; range 1..65535.
REQ-002 SHALL have parameter PERIOD_CNT, default 256: expected period in ticks.
REQ-003 SHALL have parameter TOL, default 4: allowed period deviation in ticks.
REQ-004 SHALL have parameter TIMEOUT_CNT, default 512: ticks without a rising edge before timeout; must exceed PERIOD_CNT+TOL and be at most 1023.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pwm_in  input  1  asynchronous PWM waveform to be decoded.
REQ-008 SHALL have port duty_out  output  8  last decoded duty in ticks, saturated at 255.
REQ-009 SHALL have port period_out  output  10  last measured period in ticks, saturated at 1023.
REQ-010 SHALL have port duty_valid  output  1  one-cycle strobe when duty_out/period_out update.
REQ-011 SHALL have port period_err  output  1  last period outside PERIOD_CNT±TOL.
REQ-012 SHALL have port timeout  output  1  input has been static for TIMEOUT_CNT ticks.

Function
REQ-013 SHALL pass pwm_in through a 2-flop synchronizer; the resulting level is called lvl, with a registered edge detect giving rise and fall.
REQ-014 SHALL generate tick once every PRESCALE clk cycles from a prescaler that restarts to 0 on every rise.
REQ-015 SHALL implement FSM states S_WAIT, S_HIGH and S_LOW.
REQ-016 SHALL leave S_WAIT only on rise, entering S_HIGH with high_cnt=0 and per_cnt=0; the partial period after reset or timeout is discarded.
REQ-017 SHALL, in S_HIGH, increment high_cnt and per_cnt on each tick, and go to S_LOW on fall.
REQ-018 SHALL, in S_LOW, increment per_cnt on each tick; on rise it SHALL latch the results, clear both counters and return to S_HIGH.
REQ-019 SHALL, on latch, update duty_out=min(high_cnt,255), period_out=per_cnt and period_err=(|per_cnt-PERIOD_CNT|>TOL), all registered, with duty_valid high for exactly one cycle, 1 clk after rise.
REQ-020 SHALL saturate high_cnt and per_cnt at TIMEOUT_CNT; they never wrap.
REQ-021 SHALL enter timeout when per_cnt reaches TIMEOUT_CNT in S_HIGH or S_LOW; on timeout:
- duty_out=255 if lvl=1, else 0
- period_out=TIMEOUT_CNT, period_err=1, timeout=1
- duty_valid pulses once
- FSM goes to S_WAIT
REQ-022 SHALL give rise priority over timeout in the same cycle; the rise is processed as a normal latch.
REQ-023 SHALL hold timeout at 1 until the next normal latch clears it.
REQ-024 SHALL count no ticks while in S_WAIT.
REQ-025 SHALL report a decoded duty equal to the high time of the source in ticks when the source uses PERIOD_CNT ticks per period at the same tick rate, so duty=N is recovered exactly.
REQ-026 SHALL have total latency of 3 clk from a pwm_in rising edge to duty_valid without the filter, or 5 clk with the filter (REQ-031).

Reset
REQ-027 SHALL, while rst=0, asynchronously force: FSM=S_WAIT, all counters and prescaler=0, synchronizer and filter flops=0, duty_out=0, period_out=0, duty_valid=0, period_err=0, timeout=0.
REQ-028 SHALL, on rst assertion mid-period, discard the measurement with no duty_valid; after release, wait for a fresh rise.
REQ-029 SHALL release reset with no extra synchronization; the first capture follows the first rise after release.

Configuration
REQ-030 SHALL use macro PWM_CAPTURE_GLITCH_FILTER_EN to enable a glitch filter.
REQ-031 SHALL, with PWM_CAPTURE_GLITCH_FILTER_EN defined, change lvl only after the synchronizer output holds a new value for 3 consecutive clk, so pulses of 1-2 clk are rejected (+2 clk latency).
REQ-032 SHALL, with PWM_CAPTURE_GLITCH_FILTER_EN undefined, take lvl directly from the synchronizer output, and every pulse of at least 1 clk is seen.

Verification
REQ-033 SHALL cover, with defaults: pwm_in 64 clk high / 192 clk low repeated -> from the second rise: duty_out=64, period_out=256, period_err=0, duty_valid once per period.
REQ-034 SHALL cover, with defaults: duty 0 then 255 patterns (high 0 / high 255 of 256) -> the constant-low case times out with duty_out=0; the 255 case gives duty_out=255, period_err=0.
REQ-035 SHALL cover, with defaults: pwm_in held high 600 clk after one rise -> 512 ticks after the rise, duty_out=255, period_out=512, timeout=1, period_err=1, FSM in S_WAIT; the next two rises at period 256 clear timeout.
REQ-036 SHALL cover, with defaults: period 300 clk, 100 high -> duty_out=100, period_out=300, period_err=1; period 259 -> period_err=0.
REQ-037 SHALL cover, with defaults: rst pulsed low mid-high-phase -> all outputs 0 immediately; no duty_valid until the second rise after release.
REQ-038 SHALL cover, with defaults and PWM_CAPTURE_GLITCH_FILTER_EN: a 2-clk high glitch inside the low phase of a 64/256 stream -> duty_out stays 64 and no extra duty_valid; without the macro, the same glitch produces an extra short-period capture with period_err=1.

Source files
------------

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Decodes an asynchronous PWM waveform into a duty (high time, in ticks) and a
// period (rise-to-rise, in ticks). A measurement tick is generated every
// PRESCALE clk cycles from a prescaler that restarts on every input rise.
// Results are published with a one-cycle duty_valid strobe on every rise that
// closes a period. If no rise arrives within TIMEOUT_CNT ticks, a timeout
// record is published and the decoder goes back to waiting for a fresh rise.
//
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-sample
// glitch filter after the synchronizer. Pulses of 1-2 clk are rejected and the
// rise-to-strobe latency grows from 3 to 5 clk.
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int PRESCALE    = 1,
  parameter int PERIOD_CNT  = 256,
  parameter int TOL         = 4,
  parameter int TIMEOUT_CNT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] duty_out,
  output logic [9:0] period_out,
  output logic       duty_valid,
  output logic       period_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [9:0]  TO_CNT    = 10'(TIMEOUT_CNT);
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [11:0] PER_HI    = 12'(PERIOD_CNT + TOL);
  localparam logic [11:0] PER_NOM   = 12'(PERIOD_CNT);
  localparam logic [11:0] TOL_W     = 12'(TOL);

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_lvl_d;
  logic [15:0] r_presc;
  logic [9:0]  r_high_cnt;
  logic [9:0]  r_per_cnt;

  logic        w_lvl;
  logic        w_rise;
  logic        w_fall;
  logic        w_tick;
  logic [9:0]  w_high_next;
  logic [9:0]  w_per_next;
  logic [11:0] w_per_ext;
  logic        w_per_err;
  logic        w_timeout_hit;
  logic [7:0]  w_duty_sat;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values on
      // the same edge; blocking here would collapse the chain into one flop.
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_lvl_f;

  // The level only moves once the synchronized input has shown the same value
  // on three consecutive cycles; otherwise it holds the previous level.
  assign w_lvl = ((r_sync2 == r_hist[0]) && (r_sync2 == r_hist[1])) ? r_sync2 : r_lvl_f;

  // History of the synchronizer output and the held filter level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= 2'b00;
      r_lvl_f <= 1'b0;
    end else begin
      r_hist  <= {r_hist[0], r_sync2};
      r_lvl_f <= w_lvl;
    end
  end
`else
  assign w_lvl = r_sync2;
`endif

  // Registered copy of the level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl_d <= w_lvl;
    end
  end

  assign w_rise = w_lvl & ~r_lvl_d;
  assign w_fall = ~w_lvl & r_lvl_d;

  // Tick prescaler, realigned to every rise so ticks are phase-locked to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= 16'd0;
    end else if (w_rise || w_tick) begin
      r_presc <= 16'd0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  assign w_tick = (r_presc == PRESC_MAX);

  // Counter next values include the current cycle's tick and stick at the
  // timeout count instead of wrapping.
  assign w_high_next = (w_tick && (r_high_cnt != TO_CNT)) ? r_high_cnt + 10'd1 : r_high_cnt;
  assign w_per_next  = (w_tick && (r_per_cnt  != TO_CNT)) ? r_per_cnt  + 10'd1 : r_per_cnt;

  assign w_timeout_hit = (w_per_next == TO_CNT);
  assign w_duty_sat    = (r_high_cnt > 10'd255) ? 8'hFF : r_high_cnt[7:0];

  // Period error: |period - PERIOD_CNT| > TOL, evaluated without signed math.
  assign w_per_ext = {2'b00, w_per_next};
  assign w_per_err = (w_per_ext > PER_HI) || ((w_per_ext + TOL_W) < PER_NOM);

  // Measurement FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_WAIT;
      r_high_cnt <= 10'd0;
      r_per_cnt  <= 10'd0;
      duty_out   <= 8'd0;
      period_out <= 10'd0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (w_rise) begin
            r_high_cnt <= 10'd0;
            r_per_cnt  <= 10'd0;
            r_state    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_timeout_hit) begin
            duty_out   <= w_lvl ? 8'hFF : 8'h00;
            period_out <= TO_CNT;
            period_err <= 1'b1;
            timeout    <= 1'b1;
            duty_valid <= 1'b1;
            r_high_cnt <= 10'd0;
            r_per_cnt  <= 10'd0;
            r_state    <= S_WAIT;
          end else begin
            r_high_cnt <= w_high_next;
            r_per_cnt  <= w_per_next;
            if (w_fall) begin
              r_state <= S_LOW;
            end
          end
        end
        S_LOW: begin
          if (w_rise) begin
            duty_out   <= w_duty_sat;
            period_out <= w_per_next;
            period_err <= w_per_err;
            timeout    <= 1'b0;
            duty_valid <= 1'b1;
            r_high_cnt <= 10'd0;
            r_per_cnt  <= 10'd0;
            r_state    <= S_HIGH;
          end else if (w_timeout_hit) begin
            duty_out   <= w_lvl ? 8'hFF : 8'h00;
            period_out <= TO_CNT;
            period_err <= 1'b1;
            timeout    <= 1'b1;
            duty_valid <= 1'b1;
            r_high_cnt <= 10'd0;
            r_per_cnt  <= 10'd0;
            r_state    <= S_WAIT;
          end else begin
            r_per_cnt <= w_per_next;
          end
        end
        default: begin
          r_state <= S_WAIT;
        end
      endcase
    end
  end

endmodule
